// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: FSM states, stall masks,
// trap cause codes and default redirect vectors.
package ctrl_defs;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SLEEP = 2'd3
  } state_e;

  // Stall bit order: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_BAD_PC  = 2'd2;
  localparam logic [1:0] CAUSE_IRQ     = 2'd3;

  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
  localparam logic [31:0] IRQ_VEC_DEF  = 32'h0000_0200;

  localparam int unsigned CNT_W = 8;

  // Return address after WFI; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_ctrl_cycle_cnt.sv
// Loadable down-counter with a zero flag, used to time FLUSH and DRAIN.
module ctrl_cycle_cnt
  import ctrl_defs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges stall requests, sequences branch/trap flushes
// and runs the WFI drain/sleep/wake sequence.
module pipe_ctrl
  import ctrl_defs::*;
#(
  parameter logic [31:0] TRAP_VEC     = TRAP_VEC_DEF,
  parameter logic [31:0] IRQ_VEC      = IRQ_VEC_DEF,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        inst_invalid_i,
  input  logic        pc_invalid_i,
  input  logic        is_wfi_i,
  input  logic [31:0] id_pc_i,
  input  logic        irq_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        new_pc_valid_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] epc_o,
  output logic [1:0]  cause_o,
  output logic        sleeping_o,
  output logic [1:0]  state_o
);

  // Counter reloads are one less than the cycle count: the zero cycle is the last one.
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic        npv_q, npv_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        sleep_q, sleep_d;
  logic        pend_q, pend_d;
  logic [5:0]  stall_c;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  ctrl_cycle_cnt u_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    npv_d    = 1'b0;
    new_pc_d = new_pc_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    sleep_d  = 1'b0;
    pend_d   = pend_q;
    stall_c  = STALL_NONE;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (inst_invalid_i || pc_invalid_i) begin
          epc_d    = id_pc_i;
          cause_d  = pc_invalid_i ? CAUSE_BAD_PC : CAUSE_ILLEGAL;
          new_pc_d = TRAP_VEC;
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          npv_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = FLUSH_LOAD;
        end else if (branch_flag_i) begin
          new_pc_d = branch_target_i;
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          npv_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = FLUSH_LOAD;
        end else if (stallreq_from_ex) begin
          stall_c = STALL_EX;
        end else if (stallreq_from_id) begin
          stall_c = STALL_ID;
        end else if (is_wfi_i) begin
          epc_d    = next_pc(id_pc_i);
          state_d  = ST_DRAIN;
          cnt_load = 1'b1;
          cnt_val  = DRAIN_LOAD;
        end
      end

      ST_FLUSH: begin
        if (cnt_zero) begin
          state_d = ST_RUN;
        end else begin
          flush_d = 1'b1;
          cnt_dec = 1'b1;
        end
      end

      ST_DRAIN: begin
        stall_c = STALL_ID;
        if (irq_i) begin
          pend_d = 1'b1;
        end
        if (cnt_zero) begin
          state_d = ST_SLEEP;
          sleep_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_SLEEP: begin
        stall_c = STALL_ALL;
        if (irq_i || pend_q) begin
          cause_d  = CAUSE_IRQ;
          new_pc_d = IRQ_VEC;
          pend_d   = 1'b0;
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          npv_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = FLUSH_LOAD;
        end else begin
          sleep_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      npv_q    <= 1'b0;
      new_pc_q <= '0;
      epc_q    <= '0;
      cause_q  <= CAUSE_NONE;
      sleep_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      npv_q    <= npv_d;
      new_pc_q <= new_pc_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      sleep_q  <= sleep_d;
      pend_q   <= pend_d;
    end
  end

  // Stall is combinational, so gate it with reset to keep every output low during reset.
  assign stall_o        = rst ? stall_c : STALL_NONE;
  assign flush_o        = flush_q;
  assign new_pc_valid_o = npv_q;
  assign new_pc_o       = new_pc_q;
  assign epc_o          = epc_q;
  assign cause_o        = cause_q;
  assign sleeping_o     = sleep_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: per-cycle expected outputs are queued
// with the stimulus and compared at the falling edge of that cycle.
module tb_pipe_ctrl;

  localparam int EW = 75;

  logic        clk;
  logic        rst;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_invalid_i;
  logic        pc_invalid_i;
  logic        is_wfi_i;
  logic [31:0] id_pc_i;
  logic        irq_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        new_pc_valid_o;
  logic [31:0] new_pc_o;
  logic [31:0] epc_o;
  logic [1:0]  cause_o;
  logic        sleeping_o;
  logic [1:0]  state_o;

  int checks;
  int errors;
  logic [EW-1:0] exp_q[$];

  pipe_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .branch_flag_i    (branch_flag_i),
    .branch_target_i  (branch_target_i),
    .inst_invalid_i   (inst_invalid_i),
    .pc_invalid_i     (pc_invalid_i),
    .is_wfi_i         (is_wfi_i),
    .id_pc_i          (id_pc_i),
    .irq_i            (irq_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .new_pc_valid_o   (new_pc_valid_o),
    .new_pc_o         (new_pc_o),
    .epc_o            (epc_o),
    .cause_o          (cause_o),
    .sleeping_o       (sleeping_o),
    .state_o          (state_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    stallreq_from_id = 1'b0;
    stallreq_from_ex = 1'b0;
    branch_flag_i    = 1'b0;
    branch_target_i  = 32'h0;
    inst_invalid_i   = 1'b0;
    pc_invalid_i     = 1'b0;
    is_wfi_i         = 1'b0;
    id_pc_i          = 32'h0;
    irq_i            = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, {26'h0, stall_o}, 32'h0);
    check({tag, ".flush"}, {31'h0, flush_o}, 32'h0);
    check({tag, ".npv"},   {31'h0, new_pc_valid_o}, 32'h0);
    check({tag, ".npc"},   new_pc_o, 32'h0);
    check({tag, ".epc"},   epc_o, 32'h0);
    check({tag, ".cause"}, {30'h0, cause_o}, 32'h0);
    check({tag, ".sleep"}, {31'h0, sleeping_o}, 32'h0);
  endtask

  // Called at posedge+1 with inputs for this cycle already applied; returns at next posedge+1.
  task automatic cyc(input string tag, input logic [5:0] e_stall, input logic e_flush,
                     input logic e_npv, input logic [31:0] e_npc, input logic [31:0] e_epc,
                     input logic [1:0] e_cause, input logic e_sleep);
    logic [EW-1:0] e;
    exp_q.push_back({e_stall, e_flush, e_npv, e_npc, e_epc, e_cause, e_sleep});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".stall"}, {26'h0, stall_o}, {26'h0, e[74:69]});
    check({tag, ".flush"}, {31'h0, flush_o}, {31'h0, e[68]});
    check({tag, ".npv"},   {31'h0, new_pc_valid_o}, {31'h0, e[67]});
    check({tag, ".npc"},   new_pc_o, e[66:35]);
    check({tag, ".epc"},   epc_o, e[34:3]);
    check({tag, ".cause"}, {30'h0, cause_o}, {30'h0, e[2:1]});
    check({tag, ".sleep"}, {31'h0, sleeping_o}, {31'h0, e[0]});
    @(posedge clk);
    #1;
    clr_in();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_in();
    rst = 1'b0;
    #3;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    cyc("idle", 6'b0, 0, 0, 32'h0, 32'h0, 2'd0, 0);

    stallreq_from_id = 1'b1;
    cyc("loaduse", 6'b000111, 0, 0, 32'h0, 32'h0, 2'd0, 0);
    cyc("loaduse_end", 6'b0, 0, 0, 32'h0, 32'h0, 2'd0, 0);
    stallreq_from_ex = 1'b1;
    cyc("exstall", 6'b001111, 0, 0, 32'h0, 32'h0, 2'd0, 0);
    stallreq_from_ex = 1'b1; stallreq_from_id = 1'b1;
    cyc("ex_over_id", 6'b001111, 0, 0, 32'h0, 32'h0, 2'd0, 0);
    irq_i = 1'b1;
    cyc("irq_in_run", 6'b0, 0, 0, 32'h0, 32'h0, 2'd0, 0);

    // Branch beats an EX stall in the same cycle
    stallreq_from_ex = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h40;
    cyc("br_N", 6'b0, 0, 0, 32'h0, 32'h0, 2'd0, 0);
    branch_flag_i = 1'b1; branch_target_i = 32'h80; stallreq_from_ex = 1'b1; irq_i = 1'b1;
    cyc("br_N1", 6'b0, 1, 1, 32'h40, 32'h0, 2'd0, 0);
    inst_invalid_i = 1'b1; id_pc_i = 32'h44;
    cyc("br_N2", 6'b0, 1, 0, 32'h40, 32'h0, 2'd0, 0);
    cyc("br_N3", 6'b0, 0, 0, 32'h40, 32'h0, 2'd0, 0);

    // Illegal instruction trap
    inst_invalid_i = 1'b1; id_pc_i = 32'h10; stallreq_from_id = 1'b1;
    cyc("ill_N", 6'b0, 0, 0, 32'h40, 32'h0, 2'd0, 0);
    branch_flag_i = 1'b1; branch_target_i = 32'h999;
    cyc("ill_N1", 6'b0, 1, 1, 32'h100, 32'h10, 2'd1, 0);
    branch_flag_i = 1'b1; branch_target_i = 32'h999;
    cyc("ill_N2", 6'b0, 1, 0, 32'h100, 32'h10, 2'd1, 0);
    cyc("ill_N3", 6'b0, 0, 0, 32'h100, 32'h10, 2'd1, 0);

    // Invalid PC wins the cause when both trap inputs are high
    inst_invalid_i = 1'b1; pc_invalid_i = 1'b1; id_pc_i = 32'h14; branch_flag_i = 1'b1;
    branch_target_i = 32'h50;
    cyc("bpc_N", 6'b0, 0, 0, 32'h100, 32'h10, 2'd1, 0);
    cyc("bpc_N1", 6'b0, 1, 1, 32'h100, 32'h14, 2'd2, 0);
    cyc("bpc_N2", 6'b0, 1, 0, 32'h100, 32'h14, 2'd2, 0);
    cyc("bpc_N3", 6'b0, 0, 0, 32'h100, 32'h14, 2'd2, 0);

    // WFI drain, sleep, wake by irq
    is_wfi_i = 1'b1; id_pc_i = 32'h20;
    cyc("wfi_N", 6'b0, 0, 0, 32'h100, 32'h14, 2'd2, 0);
    for (int i = 0; i < 3; i++) cyc("wfi_drain", 6'b000111, 0, 0, 32'h100, 32'h24, 2'd2, 0);
    cyc("wfi_sleep0", 6'b111111, 0, 0, 32'h100, 32'h24, 2'd2, 1);
    branch_flag_i = 1'b1; inst_invalid_i = 1'b1;
    cyc("wfi_sleep1", 6'b111111, 0, 0, 32'h100, 32'h24, 2'd2, 1);
    irq_i = 1'b1;
    cyc("wfi_sleep2", 6'b111111, 0, 0, 32'h100, 32'h24, 2'd2, 1);
    cyc("wake_N1", 6'b0, 1, 1, 32'h200, 32'h24, 2'd3, 0);
    cyc("wake_N2", 6'b0, 1, 0, 32'h200, 32'h24, 2'd3, 0);
    cyc("wake_N3", 6'b0, 0, 0, 32'h200, 32'h24, 2'd3, 0);

    // irq during DRAIN: one-cycle SLEEP; PC+4 wraps to zero
    is_wfi_i = 1'b1; id_pc_i = 32'hFFFF_FFFC;
    cyc("pend_N", 6'b0, 0, 0, 32'h200, 32'h24, 2'd3, 0);
    irq_i = 1'b1;
    cyc("pend_d1", 6'b000111, 0, 0, 32'h200, 32'h0, 2'd3, 0);
    cyc("pend_d2", 6'b000111, 0, 0, 32'h200, 32'h0, 2'd3, 0);
    cyc("pend_d3", 6'b000111, 0, 0, 32'h200, 32'h0, 2'd3, 0);
    cyc("pend_sleep", 6'b111111, 0, 0, 32'h200, 32'h0, 2'd3, 1);
    cyc("pend_w1", 6'b0, 1, 1, 32'h200, 32'h0, 2'd3, 0);
    cyc("pend_w2", 6'b0, 1, 0, 32'h200, 32'h0, 2'd3, 0);
    cyc("pend_w3", 6'b0, 0, 0, 32'h200, 32'h0, 2'd3, 0);

    // Reset in DRAIN after irq_pending is set
    is_wfi_i = 1'b1; id_pc_i = 32'h30;
    cyc("rd_N", 6'b0, 0, 0, 32'h200, 32'h0, 2'd3, 0);
    irq_i = 1'b1;
    cyc("rd_d1", 6'b000111, 0, 0, 32'h200, 32'h34, 2'd3, 0);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_drain");
    @(posedge clk);
    #1 rst = 1'b1;
    cyc("rd_after", 6'b0, 0, 0, 32'h0, 32'h0, 2'd0, 0);

    // A fresh WFI must sleep until irq: no stale pending survives reset
    is_wfi_i = 1'b1; id_pc_i = 32'h40;
    cyc("rs_N", 6'b0, 0, 0, 32'h0, 32'h0, 2'd0, 0);
    for (int i = 0; i < 3; i++) cyc("rs_drain", 6'b000111, 0, 0, 32'h0, 32'h44, 2'd0, 0);
    cyc("rs_sleep0", 6'b111111, 0, 0, 32'h0, 32'h44, 2'd0, 1);
    cyc("rs_sleep1", 6'b111111, 0, 0, 32'h0, 32'h44, 2'd0, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_sleep");
    @(posedge clk);
    #1 rst = 1'b1;
    cyc("rs_after0", 6'b0, 0, 0, 32'h0, 32'h0, 2'd0, 0);
    stallreq_from_id = 1'b1;
    cyc("rs_after1", 6'b000111, 0, 0, 32'h0, 32'h0, 2'd0, 0);
    cyc("rs_after2", 6'b0, 0, 0, 32'h0, 32'h0, 2'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage RV32 core. It merges stall requests from ID (load-use) and EX (multi-cycle ops) into a per-stage stall vector. It sequences flushes for taken branches and traps (invalid instruction, invalid PC), and runs the WFI drain/sleep/wake sequence. Its redirect PC goes to the PC register; its flush goes to the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
TRAP_VEC, 32'h0000_0100, redirect target on illegal instruction or invalid PC
IRQ_VEC, 32'h0000_0200, redirect target on wake from WFI
FLUSH_CYCLES, 2, number of cycles flush_o stays high per redirect (minimum 1)
DRAIN_CYCLES, 3, cycles spent stalling the front end so EX/MEM/WB empty before sleep (minimum 1)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low
stallreq_from_id  in  1  load-use stall request from ID
stallreq_from_ex  in  1  multi-cycle stall request from EX
branch_flag_i  in  1  taken branch/jump resolved in EX
branch_target_i  in  32  branch target address
inst_invalid_i  in  1  ID instruction is undecodable (1 = invalid)
pc_invalid_i  in  1  ID PC is misaligned or invalid
is_wfi_i  in  1  ID holds a WFI instruction
id_pc_i  in  32  PC of the instruction in ID
irq_i  in  1  external interrupt, level-sensitive
stall_o  out  6  per-stage stall: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
flush_o  out  1  clear IF/ID, ID/EX, EX/MEM
new_pc_valid_o  out  1  load new_pc_o into the PC
new_pc_o  out  32  redirect address
epc_o  out  32  saved return PC
cause_o  out  2  0 none, 1 illegal instruction, 2 invalid PC, 3 interrupt
sleeping_o  out  1  core asleep

Behaviour:
- States: RUN, FLUSH, DRAIN, SLEEP. Reset puts the FSM in RUN with every output 0 (stall_o = 6'b0, new_pc_o, epc_o and cause_o = 0).
- stall_o is combinational from the current state and inputs. All other outputs are registered.
- RUN: events are evaluated in cycle N in this priority order.
  1. inst_invalid_i or pc_invalid_i: epc_o <= id_pc_i; cause_o <= 2 if pc_invalid_i, else 1; new_pc_o <= TRAP_VEC. Go to FLUSH.
  2. branch_flag_i: new_pc_o <= branch_target_i. Go to FLUSH. cause_o and epc_o are unchanged.
  3. stallreq_from_ex: stall_o = 6'b001111. Stay in RUN.
  4. stallreq_from_id: stall_o = 6'b000111. Stay in RUN.
  5. is_wfi_i with no stall request: epc_o <= id_pc_i + 4. Go to DRAIN.
  6. Otherwise stall_o = 0.
- A trap or branch event takes precedence over a stall request in the same cycle. In that cycle stall_o = 0.
- FLUSH:
  - new_pc_valid_o is high for exactly cycle N+1.
  - flush_o is high for cycles N+1 through N+FLUSH_CYCLES. stall_o = 0 throughout.
  - Stall requests, branch_flag_i and trap inputs are ignored while in FLUSH.
  - After the last flush cycle the FSM returns to RUN.
- DRAIN:
  - stall_o = 6'b000111 for DRAIN_CYCLES cycles, timed by a down-counter, then go to SLEEP.
  - irq_i high at any point during DRAIN sets irq_pending.
- SLEEP:
  - stall_o = 6'b111111 and sleeping_o = 1, starting in the cycle after SLEEP is entered.
  - When irq_i or irq_pending is high: cause_o <= 3, new_pc_o <= IRQ_VEC, clear irq_pending, go to FLUSH. sleeping_o drops in the same edge.
  - If irq_pending was already set on entry, SLEEP lasts exactly one cycle.
- The 32-bit epc_o + 4 addition wraps modulo 2^32.
- Reset asserted mid-sequence (FLUSH, DRAIN or SLEEP) immediately forces RUN, clears all outputs, the counter and irq_pending.
- irq_i in RUN or FLUSH is ignored: it is not latched.

Decomposition:
- Shared package ctrl_defs: state encoding, stall masks STALL_NONE / STALL_ID (6'b000111) / STALL_EX (6'b001111) / STALL_ALL, cause codes, TRAP_VEC and IRQ_VEC defaults.
- One sub-module, ctrl_cycle_cnt: a loadable down-counter with a zero flag, shared by FLUSH and DRAIN.

Test Plan:
- Load-use: stallreq_from_id=1 for 1 cycle -> stall_o=6'b000111 in that cycle only; flush_o=0.
- Priority: stallreq_from_ex=1 and branch_flag_i=1 with branch_target_i=32'h0000_0040 in cycle N -> stall_o=0 in N; new_pc_valid_o=1 and new_pc_o=32'h40 in N+1; flush_o=1 in N+1 and N+2, 0 in N+3.
- Illegal instruction: inst_invalid_i=1 with id_pc_i=32'h0000_0010 -> epc_o=32'h10, cause_o=1, new_pc_o=32'h100; a branch_flag_i raised during FLUSH is ignored.
- WFI: is_wfi_i=1 with id_pc_i=32'h20 -> stall_o=6'b000111 for 3 cycles, then stall_o=6'b111111 and sleeping_o=1; irq_i=1 -> next cycle new_pc_o=32'h200, cause_o=3, epc_o=32'h24, sleeping_o=0, flush_o=1 for 2 cycles.
- irq_i pulsed during DRAIN -> SLEEP lasts exactly 1 cycle, then the IRQ_VEC redirect.
- rst driven low during SLEEP, asynchronously -> all outputs 0 immediately; after release, stays in RUN with stall_o=0 and no stale irq_pending.
